// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line fills plus D-cache writebacks onto a single memory
// controller; read lines arrive as 32-bit beats and are assembled into a 1024-bit line.
module cache_mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ic_req,
    input  logic [31:0]   ic_addr,
    output logic          ic_done,
    input  logic          dc_rreq,
    input  logic [31:0]   dc_raddr,
    output logic          dc_rdone,
    output logic [1023:0] rd_line,
    input  logic          dc_wreq,
    input  logic [31:0]   dc_waddr,
    input  logic [1023:0] dc_wdata,
    input  logic [127:0]  dc_wmask,
    output logic          dc_wdone,
    output logic          mem_raddr_valid,
    output logic [31:0]   mem_raddr,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_rdata_valid,
    output logic          mem_waddr_valid,
    output logic [31:0]   mem_waddr,
    output logic [1023:0] mem_wdata,
    output logic [127:0]  mem_wmask,
    input  logic          mem_wack,
    output logic          busy
);

    localparam int LINE_BITS = 1024;
    localparam int WORD_BITS = 32;
    localparam int BEATS     = LINE_BITS / WORD_BITS;
    localparam int MASK_BITS = LINE_BITS / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_BEATS = 3'd2,
        RD_DONE  = 3'd3,
        WR_ISSUE = 3'd4,
        WR_DONE  = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 next_s;
    logic                   gnt_ic_s;
    logic                   gnt_dc_s;
    logic                   gnt_wr_s;
    logic [31:0]            gnt_addr_s;
    logic                   rr_last_r;
    logic                   sel_dc_r;
    logic [4:0]             beat_r;
    logic [31:0]            addr_r;
    logic [LINE_BITS-1:0]   wdata_r;
    logic [MASK_BITS-1:0]   wmask_r;
    logic [LINE_BITS-1:0]   rd_line_r;
    logic                   busy_r;
    logic                   raddr_valid_r;
    logic                   waddr_valid_r;
    logic                   ic_done_r;
    logic                   dc_rdone_r;
    logic                   dc_wdone_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and grant decision; rr_last_r=1 means the I-cache was served last
    always_comb begin
        next_s   = state_r;
        gnt_ic_s = 1'b0;
        gnt_dc_s = 1'b0;
        gnt_wr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (dc_wreq) begin
                    gnt_wr_s = 1'b1;
                    next_s   = WR_ISSUE;
                end else if (ic_req && dc_rreq) begin
                    gnt_dc_s = rr_last_r;
                    gnt_ic_s = ~rr_last_r;
                    next_s   = RD_ISSUE;
                end else if (ic_req) begin
                    gnt_ic_s = 1'b1;
                    next_s   = RD_ISSUE;
                end else if (dc_rreq) begin
                    gnt_dc_s = 1'b1;
                    next_s   = RD_ISSUE;
                end else begin
                    next_s   = IDLE;
                end
            end
            RD_ISSUE: next_s = RD_BEATS;
            RD_BEATS: begin
                if (mem_rdata_valid && (beat_r == 5'(BEATS - 1))) begin
                    next_s = RD_DONE;
                end else begin
                    next_s = RD_BEATS;
                end
            end
            RD_DONE:  next_s = IDLE;
            WR_ISSUE: begin
                if (mem_wack) begin
                    next_s = WR_DONE;
                end else begin
                    next_s = WR_ISSUE;
                end
            end
            WR_DONE:  next_s = IDLE;
            default:  next_s = IDLE;
        endcase
    end

    // Address of the requester being granted this cycle, line-aligned
    always_comb begin
        gnt_addr_s = 32'd0;
        if (gnt_wr_s) begin
            gnt_addr_s = {dc_waddr[31:7], 7'd0};
        end else if (gnt_dc_s) begin
            gnt_addr_s = {dc_raddr[31:7], 7'd0};
        end else begin
            gnt_addr_s = {ic_addr[31:7], 7'd0};
        end
    end

    // Transaction latches, beat assembly and round-robin bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= 32'd0;
            wdata_r   <= '0;
            wmask_r   <= '0;
            sel_dc_r  <= 1'b0;
            rr_last_r <= 1'b0;
            beat_r    <= 5'd0;
            rd_line_r <= '0;
        end else begin
            if (gnt_wr_s || gnt_ic_s || gnt_dc_s) begin
                addr_r <= gnt_addr_s;
            end
            if (gnt_wr_s) begin
                wdata_r <= dc_wdata;
                wmask_r <= dc_wmask;
            end
            if (gnt_ic_s || gnt_dc_s) begin
                sel_dc_r <= gnt_dc_s;
            end
            // Counter wraps 31 -> 0 on its own, leaving it ready for the next line
            if ((state_r == RD_BEATS) && mem_rdata_valid) begin
                rd_line_r[{beat_r, 5'd0} +: WORD_BITS] <= mem_rdata;
                beat_r <= beat_r + 5'd1;
            end
            if (state_r == RD_DONE) begin
                rr_last_r <= ~sel_dc_r;
            end
        end
    end

    // Strobes and done pulses registered from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r        <= 1'b0;
            raddr_valid_r <= 1'b0;
            waddr_valid_r <= 1'b0;
            ic_done_r     <= 1'b0;
            dc_rdone_r    <= 1'b0;
            dc_wdone_r    <= 1'b0;
        end else begin
            busy_r        <= (next_s != IDLE);
            raddr_valid_r <= (next_s == RD_ISSUE);
            waddr_valid_r <= (next_s == WR_ISSUE);
            ic_done_r     <= (next_s == RD_DONE) && !sel_dc_r;
            dc_rdone_r    <= (next_s == RD_DONE) && sel_dc_r;
            dc_wdone_r    <= (next_s == WR_DONE);
        end
    end

    assign busy            = busy_r;
    assign mem_raddr_valid = raddr_valid_r;
    assign mem_raddr       = addr_r;
    assign mem_waddr_valid = waddr_valid_r;
    assign mem_waddr       = addr_r;
    assign mem_wdata       = wdata_r;
    assign mem_wmask       = wmask_r;
    assign ic_done         = ic_done_r;
    assign dc_rdone        = dc_rdone_r;
    assign dc_wdone        = dc_wdone_r;
    assign rd_line         = rd_line_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_cache_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req, dc_rreq, dc_wreq;
    logic [31:0]   ic_addr, dc_raddr, dc_waddr;
    logic [1023:0] dc_wdata;
    logic [127:0]  dc_wmask;
    logic          ic_done, dc_rdone, dc_wdone;
    logic [1023:0] rd_line;
    logic          mem_raddr_valid, mem_waddr_valid, mem_rdata_valid, mem_wack, busy;
    logic [31:0]   mem_raddr, mem_waddr, mem_rdata;
    logic [1023:0] mem_wdata;
    logic [127:0]  mem_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
        .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_rdone(dc_rdone),
        .rd_line(rd_line),
        .dc_wreq(dc_wreq), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata),
        .dc_wmask(dc_wmask), .dc_wdone(dc_wdone),
        .mem_raddr_valid(mem_raddr_valid), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .mem_waddr_valid(mem_waddr_valid), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wack(mem_wack),
        .busy(busy)
    );

    // Transaction-level model: kind 0 none, 1 I-cache read, 2 D-cache read, 3 write
    logic [1:0]    m_kind;
    logic          m_issue;
    logic [5:0]    m_beats;
    logic          m_done;
    logic          m_fav_dc;
    logic [31:0]   m_addr;
    logic [1023:0] m_wdata;
    logic [127:0]  m_wmask;
    logic [31:0]   m_words [32];
    logic [1023:0] exp_line;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind <= 2'd0; m_issue <= 1'b0; m_beats <= 6'd0; m_done <= 1'b0;
            m_fav_dc <= 1'b0; m_addr <= 32'd0; m_wdata <= '0; m_wmask <= '0;
            for (int i = 0; i < 32; i++) m_words[i] <= 32'd0;
        end else if (m_kind == 2'd0) begin
            if (dc_wreq) begin
                m_kind <= 2'd3; m_addr <= dc_waddr & ~32'h7F;
                m_wdata <= dc_wdata; m_wmask <= dc_wmask;
            end else if (ic_req && (!dc_rreq || !m_fav_dc)) begin
                m_kind <= 2'd1; m_addr <= ic_addr & ~32'h7F; m_issue <= 1'b1; m_beats <= 6'd0;
            end else if (dc_rreq) begin
                m_kind <= 2'd2; m_addr <= dc_raddr & ~32'h7F; m_issue <= 1'b1; m_beats <= 6'd0;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_kind <= 2'd0;
            if (m_kind == 2'd1) m_fav_dc <= 1'b1;
            if (m_kind == 2'd2) m_fav_dc <= 1'b0;
        end else if (m_kind == 2'd3) begin
            if (mem_wack) m_done <= 1'b1;
        end else if (m_issue) begin
            m_issue <= 1'b0;
        end else if (mem_rdata_valid) begin
            m_words[m_beats[4:0]] <= mem_rdata;
            m_beats <= m_beats + 6'd1;
            if (m_beats == 6'd31) m_done <= 1'b1;
        end
    end

    always_comb begin
        exp_line = '0;
        for (int i = 0; i < 32; i++) exp_line[i*32 +: 32] = m_words[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = 0; i < 32; i++) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s word %0d: got %h expected %h", name, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_kind != 2'd0));
        check("mem_raddr_valid", 32'(mem_raddr_valid), 32'((m_kind == 2'd1 || m_kind == 2'd2) && m_issue));
        if (m_issue) check("mem_raddr", mem_raddr, m_addr);
        check("mem_waddr_valid", 32'(mem_waddr_valid), 32'(m_kind == 2'd3 && !m_done));
        if (m_kind == 2'd3 && !m_done) begin
            check("mem_waddr", mem_waddr, m_addr);
            check_wide("mem_wdata", mem_wdata, m_wdata);
            check_wide("mem_wmask", 1024'(mem_wmask), 1024'(m_wmask));
        end
        check("ic_done", 32'(ic_done), 32'(m_done && m_kind == 2'd1));
        check("dc_rdone", 32'(dc_rdone), 32'(m_done && m_kind == 2'd2));
        check("dc_wdone", 32'(dc_wdone), 32'(m_done && m_kind == 2'd3));
        check_wide("rd_line", rd_line, exp_line);
        if (!rst_n) begin
            check("rst_raddr", mem_raddr, 32'd0);
            check("rst_waddr", mem_waddr, 32'd0);
            check_wide("rst_wdata", mem_wdata, 1024'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ic_req = 1'b0; dc_rreq = 1'b0; dc_wreq = 1'b0;
        mem_rdata_valid = 1'b0; mem_wack = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_raddr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_raddr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_raddr");
    endtask

    // Beats every (gap+1) cycles starting the cycle after the issue strobe
    task automatic feed_beats(input logic [31:0] base, input int gap, input int nbeats);
        int k = 0;
        int c = 0;
        while (k < nbeats) begin
            @(negedge clk);
            mem_wack = 1'b0;
            if (c % (gap + 1) == 0) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = base + 32'(k);
                k++;
            end else begin
                mem_rdata_valid = 1'b0;
                mem_rdata = 32'hBAD0_0000;
            end
            c++;
        end
        @(negedge clk);
        mem_rdata_valid = 1'b0;
    endtask

    task automatic wait_done(output int who);
        who = 0;
        for (int i = 0; i < 40; i++) begin
            if (ic_done) who = 1;
            else if (dc_rdone) who = 2;
            else if (dc_wdone) who = 3;
            if (who != 0) break;
            @(negedge clk);
        end
        if (who == 0) timeout("wait_done");
    endtask

    task automatic serve_read(input string name, input logic [31:0] base, input int gap,
                              input logic [31:0] exp_addr, input bit stray, output int who);
        bit ok;
        who = 0;
        wait_raddr(ok);
        if (ok) begin
            check({name, "_addr"}, mem_raddr, exp_addr);
            if (stray) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                mem_wack = 1'b1;
            end
            feed_beats(base, gap, 32);
            wait_done(who);
            if (who == 1) ic_req = 1'b0;
            if (who == 2) dc_rreq = 1'b0;
        end
    endtask

    initial begin
        int who;
        int wcnt;
        bit ok;
        rst_n = 1'b0;
        ic_req = 1'b0; dc_rreq = 1'b0; dc_wreq = 1'b0;
        ic_addr = 32'd0; dc_raddr = 32'd0; dc_waddr = 32'd0;
        dc_wdata = '0; dc_wmask = '0;
        mem_rdata = 32'd0; mem_rdata_valid = 1'b0; mem_wack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check_wide("reset_rd_line", rd_line, 1024'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Stray strobes while idle
        mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_wack = 1'b1;
        @(negedge clk);
        mem_rdata_valid = 1'b0; mem_wack = 1'b0;
        @(negedge clk);
        check("stray_idle_busy", 32'(busy), 32'd0);

        // Single I-cache read, with stray strobes during the issue cycle
        ic_req = 1'b1; ic_addr = 32'h0000_1234;
        serve_read("single", 32'h100, 0, 32'h0000_1200, 1'b1, who);
        check("single_who", 32'(who), 32'd1);
        check("single_word0", rd_line[31:0], 32'h0000_0100);
        check("single_word31", rd_line[1023:992], 32'h0000_011F);

        // Contention from reset: I, D, then I again
        do_reset();
        ic_req = 1'b1; ic_addr = 32'h0000_2010;
        dc_rreq = 1'b1; dc_raddr = 32'h0000_3040;
        serve_read("cont1", 32'h200, 0, 32'h0000_2000, 1'b0, who);
        check("cont1_who", 32'(who), 32'd1);
        serve_read("cont2", 32'h300, 0, 32'h0000_3000, 1'b0, who);
        check("cont2_who", 32'(who), 32'd2);
        check("cont2_word5", rd_line[191:160], 32'h0000_0305);
        @(negedge clk);
        ic_req = 1'b1; dc_rreq = 1'b1;
        serve_read("cont3", 32'h400, 0, 32'h0000_2000, 1'b0, who);
        check("cont3_who", 32'(who), 32'd1);
        serve_read("cont4", 32'h480, 0, 32'h0000_3000, 1'b0, who);
        check("cont4_who", 32'(who), 32'd2);

        // Write priority with a 5-cycle delayed acknowledge
        do_reset();
        for (int i = 0; i < 32; i++) dc_wdata[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        dc_wmask = {16{8'hF0}};
        dc_wreq = 1'b1; dc_waddr = 32'h4444_44FF;
        dc_rreq = 1'b1; dc_raddr = 32'h0000_5000;
        ic_req = 1'b1; ic_addr = 32'h0000_6000;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_raddr_valid) check("wr_first_no_read", 32'(mem_raddr_valid), 32'd0);
            if (mem_waddr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("wr_issue");
        end else begin
            check("wr_addr", mem_waddr, 32'h4444_4480);
            check("wr_word7", mem_wdata[255:224], 32'hA5A5_0007);
            wcnt = 1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (mem_waddr_valid) wcnt++;
            end
            check("wr_valid_cycles", 32'(wcnt), 32'd5);
            mem_wack = 1'b1;
            @(negedge clk);
            mem_wack = 1'b0;
            check("wr_valid_dropped", 32'(mem_waddr_valid), 32'd0);
            check("wr_done_pulse", 32'(dc_wdone), 32'd1);
            dc_wreq = 1'b0;
        end
        serve_read("wr_then_ic", 32'h600, 0, 32'h0000_6000, 1'b0, who);
        check("wr_then_ic_who", 32'(who), 32'd1);
        serve_read("wr_then_dc", 32'h680, 0, 32'h0000_5000, 1'b0, who);
        check("wr_then_dc_who", 32'(who), 32'd2);

        // Gapped beats: one beat every third cycle
        dc_rreq = 1'b1; dc_raddr = 32'h0000_5555;
        serve_read("gap", 32'h500, 2, 32'h0000_5500, 1'b0, who);
        check("gap_who", 32'(who), 32'd2);
        check("gap_word31", rd_line[1023:992], 32'h0000_051F);

        // Reset after beat 10, then a clean refill
        ic_req = 1'b1; ic_addr = 32'h0000_7000;
        wait_raddr(ok);
        if (ok) feed_beats(32'h700, 0, 11);
        #2 rst_n = 1'b0;
        ic_req = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'({ic_done, dc_rdone, dc_wdone}), 32'd0);
        check_wide("midrst_line", rd_line, 1024'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h0000_7080;
        serve_read("refill", 32'h800, 0, 32'h0000_7080, 1'b0, who);
        check("refill_who", 32'(who), 32'd1);
        check("refill_word0", rd_line[31:0], 32'h0000_0800);
        check("refill_word31", rd_line[1023:992], 32'h0000_081F);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
Parameters (fixed, not overridable): name, default, meaning
REQ-001 The block SHALL use LINE_BITS, 1024, cache line width in bits.
REQ-002 The block SHALL use WORD_BITS, 32, memory controller read beat width.
REQ-003 The block SHALL use BEATS, 32, read beats per line (LINE_BITS/WORD_BITS).
Ports: name  direction  width  meaning
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have the following requester ports:
- ic_req  in  1  I-cache line-fill request (level).
- ic_addr  in  32  I-cache fill address.
- ic_done  out  1  I-cache fill-complete pulse.
- dc_rreq  in  1  D-cache line-fill request (level).
- dc_raddr  in  32  D-cache fill address.
- dc_rdone  out  1  D-cache fill-complete pulse.
- rd_line  out  1024  assembled fill line.
- dc_wreq  in  1  D-cache writeback request (level).
- dc_waddr  in  32  writeback address.
- dc_wdata  in  1024  writeback line data.
- dc_wmask  in  128  writeback byte enables.
- dc_wdone  out  1  writeback-complete pulse.
REQ-006 The block SHALL have the following memory-controller ports:
- mem_raddr_valid  out  1  read address strobe.
- mem_raddr  out  32  read line address.
- mem_rdata  in  32  read beat data.
- mem_rdata_valid  in  1  read beat strobe.
- mem_waddr_valid  out  1  write request (level).
- mem_waddr  out  32  write line address.
- mem_wdata  out  1024  write line data.
- mem_wmask  out  128  write byte enables.
- mem_wack  in  1  write accepted.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 The FSM SHALL have exactly the states IDLE, RD_ISSUE, RD_BEATS, RD_DONE, WR_ISSUE and WR_DONE.
REQ-008 In IDLE, grant priority SHALL be: dc_wreq over any read request; between ic_req and dc_rreq, round-robin via a 1-bit rr_last (favour the requester not served last); if only one read is pending, grant it.
REQ-009 On a grant, the block SHALL latch the address with bits [6:0] forced to 0 (128-byte line alignment); for writes it SHALL also latch data and mask; requester inputs are don't-care after the grant cycle.
REQ-010 Read path:
- Grant in IDLE at cycle N -> RD_ISSUE at N+1, with mem_raddr_valid=1 for exactly that one cycle and mem_raddr = latched address.
- RD_ISSUE -> RD_BEATS unconditionally.
REQ-011 In RD_BEATS, each cycle with mem_rdata_valid=1 SHALL write mem_rdata into rd_line[32k+31:32k], where k is a 5-bit beat counter starting at 0; mem_rdata_valid outside RD_BEATS SHALL be ignored.
REQ-012 On capture of beat k=31, the counter SHALL wrap to 0 and the FSM SHALL go to RD_DONE.
REQ-013 In RD_DONE, the block SHALL pulse ic_done or dc_rdone (the granted requester only) for one cycle, update rr_last, and return to IDLE; rd_line SHALL hold its value until the next read's first beat.
REQ-014 Write path:
- Grant -> WR_ISSUE, where mem_waddr_valid=1 with mem_waddr/mem_wdata/mem_wmask stable until mem_wack is sampled high.
- On mem_wack -> WR_DONE: mem_waddr_valid=0, dc_wdone pulses one cycle, then IDLE.
REQ-015 mem_wack outside WR_ISSUE SHALL be ignored.
REQ-016 Requests arriving while the block is not in IDLE SHALL wait; at most one transaction SHALL be outstanding.
REQ-017 In IDLE, each done output SHALL be 0 and each strobe output SHALL be 0.
REQ-018 A request that is still asserted in the cycle its done pulses SHALL NOT be re-granted in that cycle; requesters drop req on done.

Reset
REQ-019 While rst_n=0 (asynchronous), the following SHALL hold: state=IDLE, beat counter=0, rr_last=0 (I-cache favoured first), rd_line=0, latched address/data/mask=0, and all outputs=0.
REQ-020 A reset asserted mid-transaction SHALL abandon it with no done pulse; requesters must reissue.

Verification
REQ-021 The bench SHALL cover single read: ic_req=1, ic_addr=0x0000_1234 -> mem_raddr_valid one cycle with mem_raddr=0x0000_1200; beats 0..31 with values 0x100+k -> ic_done one cycle after the 32nd beat, rd_line[31:0]=0x100, rd_line[1023:992]=0x11F.
REQ-022 The bench SHALL cover contention: ic_req and dc_rreq asserted together from reset -> I-cache served first, then D-cache; repeated together again -> I-cache served again (rr alternation).
REQ-023 The bench SHALL cover write priority: dc_wreq, dc_rreq and ic_req asserted in the same cycle -> WR_ISSUE first; with mem_wack delayed 5 cycles, mem_waddr_valid stays high 5 cycles and dc_wdone pulses after mem_wack.
REQ-024 The bench SHALL cover stray strobes: mem_rdata_valid in IDLE/RD_ISSUE and mem_wack in IDLE -> no counter change, no done pulse.
REQ-025 The bench SHALL cover reset mid-fill: rst_n=0 after beat 10 -> immediate IDLE, all outputs 0, no done pulse; a re-request then completes a full 32 beats normally.
REQ-026 The bench SHALL cover gapped beats: mem_rdata_valid asserted every third cycle -> line assembles correctly and done pulses only after 32 beats.
